// File: rtl/jk_excitation_driver.sv
// Drives a bank of JK flops toward a requested value, checks the feedback and re-drives on mismatch.
// Build option JK_TOGGLE_EN: changing bits are excited with 11 (toggle) instead of set/reset codes.
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [WIDTH-1:0]   tgt,
  output logic [2*WIDTH-1:0] jk,
  input  logic [WIDTH-1:0]   q_fb,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               err_clr
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t           state_q;
  logic [WIDTH-1:0] tgt_q, cur_q;
  logic [2:0]       cnt_q;
  logic             err_q;
  logic             match, last;

  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] t);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef JK_TOGGLE_EN
      if (c[i] != t[i]) r[2*i +: 2] = 2'b11;
`else
      if (!c[i] && t[i]) r[2*i +: 2] = 2'b10;
      if (c[i] && !t[i]) r[2*i +: 2] = 2'b01;
`endif
    end
    return r;
  endfunction

  assign match     = (q_fb == tgt_q);
  assign last      = (cnt_q == MAX_R);
  // rst gates the handshake and done so an aborted request never reports completion
  assign tgt_ready = ~rst & (state_q == IDLE);
  assign done      = ~rst & (state_q == CHECK) & (match | last);
  assign busy      = (state_q != IDLE);
  assign jk        = (state_q == DRIVE) ? excite(cur_q, tgt_q) : '0;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (err_clr) err_q <= 1'b0;
      unique case (state_q)
        IDLE: if (tgt_valid) begin
          tgt_q   <= tgt;
          cur_q   <= q_fb;
          cnt_q   <= '0;
          state_q <= DRIVE;
        end
        DRIVE: state_q <= CHECK;
        CHECK: begin
          if (match) begin
            state_q <= IDLE;
          end else if (!last) begin
            cnt_q   <= cnt_q + 3'd1;
            cur_q   <= q_fb;
            state_q <= DRIVE;
          end else begin
            // a failing request sets err even when err_clr is high
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver: a JK flop bank model closes the loop, or feedback is forced stuck.
module tb_jk_excitation_driver;
  localparam int W  = 4;
  localparam int MR = 2;

  typedef struct packed {
    logic [2*W-1:0] jk;
    logic           done;
    logic           err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, tgt_valid, err_clr;
  logic [W-1:0]   tgt;
  logic           tgt_ready, busy, done, err;
  logic [2*W-1:0] jk;
  logic [W-1:0]   q_fb, q_m, stuck_val;
  logic           stuck_en;
  logic           mon_en, model_err;
  int             vecs, miss;
  exp_t           sbq[$];

  jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt(tgt),
    .jk(jk), .q_fb(q_fb), .busy(busy), .done(done), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // JK flop bank: 00 hold, 01 reset, 10 set, 11 toggle
  function automatic logic [W-1:0] flop_next(input logic [W-1:0] q, input logic [2*W-1:0] e);
    logic [W-1:0] n;
    n = q;
    for (int i = 0; i < W; i++)
      case ({e[2*i+1], e[2*i]})
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        2'b11:   n[i] = ~q[i];
        default: n[i] = q[i];
      endcase
    return n;
  endfunction

  always @(posedge clk) q_m <= rst ? '0 : flop_next(q_m, jk);
  assign q_fb = stuck_en ? stuck_val : q_m;

  // excitation from the direction each bit has to move
  function automatic logic [2*W-1:0] exc(input logic [W-1:0] c, input logic [W-1:0] t);
    logic [2*W-1:0] r;
    int d;
    r = '0;
    for (int i = 0; i < W; i++) begin
      d = int'(t[i]) - int'(c[i]);
`ifdef JK_TOGGLE_EN
      if (d != 0) r = r | (2*W)'(3 << (2*i));
`else
      if (d > 0) r = r | (2*W)'(2 << (2*i));
      if (d < 0) r = r | (2*W)'(1 << (2*i));
`endif
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (busy || done)) begin
      if (sbq.size() == 0) begin
        vecs++; miss++;
        $display("FAIL sb_unexpected: busy=%0b done=%0b with empty queue at %0t", busy, done, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_jk", 32'(jk), 32'(e.jk));
        chk("sb_done", 32'(done), 32'(e.done));
        chk("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the request completes.
  task automatic send(input logic [W-1:0] t, input bit stuck, input logic [W-1:0] sv,
                      input bit hold, input logic [W-1:0] alt,
                      input bit cjk, input logic [2*W-1:0] ejk);
    logic [W-1:0] cur;
    logic [2*W-1:0] e;
    bit fail, ok;
    stuck_en = stuck; stuck_val = sv;
    #0;
    cur  = stuck ? sv : q_m;
    e    = exc(cur, t);
    fail = stuck && (cur != t);
    if (!fail) begin
      sbq.push_back('{jk: e, done: 1'b0, err: model_err});
      sbq.push_back('{jk: '0, done: 1'b1, err: model_err});
    end else begin
      for (int r = 0; r <= MR; r++) begin
        sbq.push_back('{jk: e, done: 1'b0, err: model_err});
        sbq.push_back('{jk: '0, done: (r == MR), err: model_err});
      end
    end
    tgt = t; tgt_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) tgt = alt; else tgt_valid = 1'b0;
    if (cjk) chk("jk_const", 32'(jk), 32'(ejk));
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    tgt_valid = 1'b0;
    if (!ok) begin
      vecs++; miss++;
      $display("FAIL done_timeout: no done within 40 cycles for tgt %0h", t);
    end
    if (!stuck) chk("q_at_done", 32'(q_fb), 32'(t));
    @(posedge clk); #1;
    if (fail) model_err = 1'b1;
    chk("err_after", 32'(err), 32'(model_err));
    chk("ready_after", 32'(tgt_ready), 32'(1));
    chk("busy_after", 32'(busy), 32'(0));
  endtask

  initial begin
    logic [2*W-1:0] c32, c33, c34;
    logic [W-1:0] t, a;
    vecs = 0; miss = 0; mon_en = 1'b0; model_err = 1'b0;
    rst = 1'b1; tgt_valid = 1'b0; err_clr = 1'b0; tgt = '0;
    stuck_en = 1'b0; stuck_val = '0;
`ifdef JK_TOGGLE_EN
    c32 = 8'b11001100; c33 = 8'b11001100; c34 = 8'b00000011;
`else
    c32 = 8'b10001000; c33 = 8'b01000100; c34 = 8'b00000010;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(tgt_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_jk", 32'(jk), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rst = 1'b0; #1;
    chk("ready_post_rst", 32'(tgt_ready), 32'(1));
    mon_en = 1'b1;

    send(4'b1010, 0, '0, 0, '0, 1, c32);
    send(4'b1111, 0, '0, 0, '0, 0, '0);
    send(4'b0101, 0, '0, 0, '0, 1, c33);
    send(4'b0001, 1, 4'b0000, 0, '0, 1, c34);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0; model_err = 1'b0;
    chk("err_clr", 32'(err), 32'(0));
    send(q_m, 0, '0, 0, '0, 1, '0);
    send(4'b0110, 0, '0, 1, 4'b1001, 0, '0);
    // err_clr held through a failing request: the set must win
    err_clr = 1'b1;
    send(4'b1000, 1, 4'b0000, 0, '0, 0, '0);
    err_clr = 1'b0; @(posedge clk); #1;
    chk("err_set_wins", 32'(err), 32'(1));
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0; model_err = 1'b0;

    // reset during DRIVE aborts without done
    mon_en = 1'b0; stuck_en = 1'b0;
    tgt = 4'b0011; tgt_valid = 1'b1;
    @(posedge clk); #1; tgt_valid = 1'b0;
    chk("abort_in_drive", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_jk", 32'(jk), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_ready_in_rst", 32'(tgt_ready), 32'(0));
    rst = 1'b0; #1;
    chk("abort_ready_after", 32'(tgt_ready), 32'(1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
    end
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      t = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      send(t, 0, '0, ($urandom_range(0, 3) == 0), a, 0, '0);
    end
    for (int i = 0; i < 4; i++) begin
      t = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      send(t, 1, a, 0, '0, 0, '0);
    end
    @(posedge clk); #1;
    chk("sb_drained", 32'(sbq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
